// File: rtl/sync_fifo_flex_pkg.sv
// Shared constants and helpers for the flexible synchronous FIFO.
package sync_fifo_pkg;

   // Read-mode selectors for the FWFT parameter
   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Address width needed to index a memory of the given depth
   function automatic int fifo_addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sync_fifo_flex_regmem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module fifo_regmem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                                clk,
   input  logic                                wr_en,
   input  logic [fifo_addr_w(DEPTH)-1:0]       wr_addr,
   input  logic [DATA_WIDTH-1:0]               wr_data,
   input  logic [fifo_addr_w(DEPTH)-1:0]       rd_addr,
   output logic [DATA_WIDTH-1:0]               rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Store the pushed word at the write address
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with selectable registered or first-word-fall-through
// read, occupancy level, almost flags, sticky error flags and flush.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int FWFT       = FIFO_MODE_STD,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      chip_select,
   input  logic                      write_enable,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic                      read_enable,
   input  logic                      flush,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      data_valid,
   output logic                      fifo_full,
   output logic                      fifo_empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int AW = fifo_addr_w(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_req, rd_req, wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   // Flags come straight from the registered pointers; the MSB is the lap bit
   assign level        = wr_ptr_q - rd_ptr_q;
   assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
   assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign almost_full  = (level >= AF_LVL);
   assign almost_empty = (level <= AE_LVL);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Accept/reject decisions, pointer advance and sticky error flags
   always_comb begin
      wr_req      = chip_select & write_enable;
      rd_req      = chip_select & read_enable;
      wr_acc      = wr_req & ~fifo_full & ~flush;
      rd_acc      = rd_req & ~fifo_empty & ~flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         // Flush wins: same-cycle requests are dropped without flagging
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
         if (wr_req && fifo_full)  overflow_d  = 1'b1;
         if (rd_req && fifo_empty) underflow_d = 1'b1;
      end
   end

   // Pointer and error-flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_regmem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (mem_rd_data)
   );

   if (FWFT == FIFO_MODE_STD) begin : g_std
      logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
      logic                  data_valid_q, data_valid_d;

      // Capture the head word on an accepted read; otherwise hold data_out
      always_comb begin
         data_out_d   = data_out_q;
         data_valid_d = rd_acc;
         if (rd_acc) data_out_d = mem_rd_data;
      end

      // Registered read-data stage
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
         end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
         end
      end

      assign data_out   = data_out_q;
      assign data_valid = data_valid_q;
   end else begin : g_fwft
      // Head word shown directly; forced to zero when empty so the
      // unreset memory never leaks X onto data_out
      assign data_out   = fifo_empty ? '0 : mem_rd_data;
      assign data_valid = ~fifo_empty;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: one standard-mode and one FWFT
// instance share stimulus; a queue-based model predicts data and flags.
module tb_sync_fifo_flex;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       chip_select = 1'b0;
   logic       write_enable = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       read_enable = 1'b0;
   logic       flush = 1'b0;

   logic [7:0] data_out, f_data_out;
   logic       data_valid, fifo_full, fifo_empty, almost_full, almost_empty;
   logic       overflow, underflow;
   logic [3:0] level;
   logic       f_data_valid, f_fifo_full, f_fifo_empty, f_almost_full;
   logic       f_almost_empty, f_overflow, f_underflow;
   logic [3:0] f_level;

   int         n_checks = 0;
   int         n_pass = 0;

   logic [7:0] sb[$];
   int         mdl_cnt = 0;
   bit         mdl_ovf = 1'b0;
   bit         mdl_udf = 1'b0;
   bit         exp_valid = 1'b0;
   logic [7:0] exp_data = 8'h00;

   always #5 clk = ~clk;

   sync_fifo_flex #(
      .DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)
   ) dut (
      .clk(clk), .reset(reset), .chip_select(chip_select),
      .write_enable(write_enable), .data_in(data_in),
      .read_enable(read_enable), .flush(flush),
      .data_out(data_out), .data_valid(data_valid),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .level(level), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_flex #(
      .DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)
   ) dut_fwft (
      .clk(clk), .reset(reset), .chip_select(chip_select),
      .write_enable(write_enable), .data_in(data_in),
      .read_enable(read_enable), .flush(flush),
      .data_out(f_data_out), .data_valid(f_data_valid),
      .fifo_full(f_fifo_full), .fifo_empty(f_fifo_empty),
      .almost_full(f_almost_full), .almost_empty(f_almost_empty),
      .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
   );

   // One clock of stimulus; the model pushes accepted writes and pops the
   // expected read word, then outputs are sampled 1 ns after the edge.
   task automatic step(input bit cs, input bit we, input logic [7:0] d,
                       input bit re, input bit fl);
      bit wr_ok, rd_ok;
      @(negedge clk);
      chip_select = cs; write_enable = we; data_in = d;
      read_enable = re; flush = fl;
      wr_ok = cs && we && !fl && (mdl_cnt < 8);
      rd_ok = cs && re && !fl && (mdl_cnt > 0);
      if (fl) begin
         sb.delete();
         mdl_cnt = 0; mdl_ovf = 1'b0; mdl_udf = 1'b0;
      end else begin
         if (cs && we && !wr_ok) mdl_ovf = 1'b1;
         if (cs && re && !rd_ok) mdl_udf = 1'b1;
         if (rd_ok) exp_data = sb.pop_front();
         if (wr_ok) sb.push_back(d);
         mdl_cnt = mdl_cnt + int'(wr_ok) - int'(rd_ok);
      end
      exp_valid = rd_ok;
      @(posedge clk);
      #1;
      chip_select = 1'b0; write_enable = 1'b0; read_enable = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      sb.delete(); mdl_cnt = 0; mdl_ovf = 1'b0; mdl_udf = 1'b0;
      #1;
      n_checks++; if (level !== 4'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (fifo_empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", fifo_empty); else n_pass++;
      n_checks++; if (fifo_full !== 1'b0) $display("FAIL rst_full: got %b want 0", fifo_full); else n_pass++;
      n_checks++; if (almost_empty !== 1'b1) $display("FAIL rst_ae: got %b want 1", almost_empty); else n_pass++;
      n_checks++; if (almost_full !== 1'b0) $display("FAIL rst_af: got %b want 0", almost_full); else n_pass++;
      n_checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL rst_err: got %b%b want 00", overflow, underflow); else n_pass++;
      n_checks++; if (data_out !== 8'h00) $display("FAIL rst_dout: got %h want 00", data_out); else n_pass++;
      n_checks++; if (data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", data_valid); else n_pass++;
      n_checks++; if (f_data_valid !== 1'b0) $display("FAIL rst_fwft_valid: got %b want 0", f_data_valid); else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 8'(i + 1), 0, 0);
         $display("write %h level %0d", 8'(i + 1), level);
         n_checks++; if (level !== 4'(mdl_cnt)) $display("FAIL fill_level: got %0d want %0d", level, mdl_cnt); else n_pass++;
         n_checks++; if (almost_empty !== (mdl_cnt <= 2)) $display("FAIL fill_ae: got %b want %b", almost_empty, mdl_cnt <= 2); else n_pass++;
         n_checks++; if (almost_full !== (mdl_cnt >= 6)) $display("FAIL fill_af: got %b want %b", almost_full, mdl_cnt >= 6); else n_pass++;
      end
      n_checks++; if (fifo_full !== 1'b1) $display("FAIL fill_full: got %b want 1", fifo_full); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 8'h00, 1, 0);
         $display("read %h valid %b", data_out, data_valid);
         n_checks++; if (data_valid !== exp_valid) $display("FAIL drain_valid: got %b want %b", data_valid, exp_valid); else n_pass++;
         n_checks++; if (data_out !== exp_data) $display("FAIL drain_data: got %h want %h", data_out, exp_data); else n_pass++;
      end
      step(0, 0, 8'h00, 0, 0);
      n_checks++; if (data_valid !== 1'b0) $display("FAIL drain_valid_drop: got %b want 0", data_valid); else n_pass++;
      n_checks++; if (data_out !== 8'h08) $display("FAIL drain_hold: got %h want 08", data_out); else n_pass++;
      n_checks++; if (fifo_empty !== 1'b1 || level !== 4'd0) $display("FAIL drain_end: got empty %b level %0d want 1/0", fifo_empty, level); else n_pass++;
   endtask

   task automatic test_overflow_underflow();
      for (int i = 0; i < 8; i++) step(1, 1, 8'(8'hC0 + i), 0, 0);
      step(1, 1, 8'h55, 0, 0);
      $display("write 55 while full level %0d ovf %b", level, overflow);
      n_checks++; if (level !== 4'd8) $display("FAIL ovf_level: got %0d want 8", level); else n_pass++;
      n_checks++; if (overflow !== mdl_ovf) $display("FAIL ovf_flag: got %b want %b", overflow, mdl_ovf); else n_pass++;
      step(0, 0, 8'h00, 0, 0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 8'h00, 1, 0);
         $display("read %h", data_out);
         n_checks++; if (data_out !== exp_data || data_valid !== 1'b1) $display("FAIL ovf_contents: got %h/%b want %h/1", data_out, data_valid, exp_data); else n_pass++;
      end
      step(1, 0, 8'h00, 1, 0);
      $display("read while empty udf %b valid %b", underflow, data_valid);
      n_checks++; if (underflow !== mdl_udf) $display("FAIL udf_flag: got %b want %b", underflow, mdl_udf); else n_pass++;
      n_checks++; if (data_valid !== 1'b0) $display("FAIL udf_valid: got %b want 0", data_valid); else n_pass++;
      step(0, 0, 8'h00, 0, 1);
      $display("flush ovf %b udf %b", overflow, underflow);
      n_checks++; if ({overflow, underflow} !== {mdl_ovf, mdl_udf}) $display("FAIL flush_err: got %b%b want %b%b", overflow, underflow, mdl_ovf, mdl_udf); else n_pass++;
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h10 + i), 0, 0);
      step(1, 1, 8'h20, 1, 0);
      $display("wr+rd at 4: level %0d dout %h", level, data_out);
      n_checks++; if (level !== 4'd4) $display("FAIL sim_level4: got %0d want 4", level); else n_pass++;
      n_checks++; if (data_out !== exp_data) $display("FAIL sim_order: got %h want %h", data_out, exp_data); else n_pass++;
      for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h21 + i), 0, 0);
      step(1, 1, 8'h99, 1, 0);
      $display("wr+rd full: level %0d ovf %b dout %h", level, overflow, data_out);
      n_checks++; if (level !== 4'd7) $display("FAIL sim_full_level: got %0d want 7", level); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL sim_full_ovf: got %b want 1", overflow); else n_pass++;
      n_checks++; if (data_out !== exp_data) $display("FAIL sim_full_data: got %h want %h", data_out, exp_data); else n_pass++;
      while (mdl_cnt > 0) begin
         step(1, 0, 8'h00, 1, 0);
         n_checks++; if (data_out !== exp_data || data_valid !== 1'b1) $display("FAIL sim_drain: got %h/%b want %h/1", data_out, data_valid, exp_data); else n_pass++;
      end
      step(0, 0, 8'h00, 0, 1);
      step(1, 1, 8'h30, 1, 0);
      $display("wr+rd empty: level %0d udf %b", level, underflow);
      n_checks++; if (level !== 4'd1) $display("FAIL sim_empty_level: got %0d want 1", level); else n_pass++;
      n_checks++; if (underflow !== 1'b1) $display("FAIL sim_empty_udf: got %b want 1", underflow); else n_pass++;
      n_checks++; if (data_valid !== 1'b0) $display("FAIL sim_empty_valid: got %b want 0", data_valid); else n_pass++;
      step(1, 0, 8'h00, 1, 0);
      n_checks++; if (data_out !== exp_data) $display("FAIL sim_empty_data: got %h want %h", data_out, exp_data); else n_pass++;
      step(0, 0, 8'h00, 0, 1);
   endtask

   task automatic test_wrap();
      // Level held at 3 while pointers advance 20 places (two MSB toggles)
      for (int i = 0; i < 3; i++) step(1, 1, 8'(i), 0, 0);
      for (int i = 3; i < 20; i++) begin
         step(1, 1, 8'(i), 1, 0);
         $display("wrap push %h pop %h level %0d", 8'(i), data_out, level);
         n_checks++; if (data_out !== exp_data || data_valid !== 1'b1) $display("FAIL wrap_data: got %h/%b want %h/1", data_out, data_valid, exp_data); else n_pass++;
         n_checks++; if (fifo_full !== 1'b0 || fifo_empty !== 1'b0 || level !== 4'd3) $display("FAIL wrap_flags: got full %b empty %b level %0d want 0/0/3", fifo_full, fifo_empty, level); else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 8'h00, 1, 0);
         n_checks++; if (data_out !== exp_data) $display("FAIL wrap_tail: got %h want %h", data_out, exp_data); else n_pass++;
      end
      n_checks++; if (fifo_empty !== 1'b1) $display("FAIL wrap_end_empty: got %b want 1", fifo_empty); else n_pass++;
   endtask

   task automatic test_fwft();
      step(0, 0, 8'h00, 0, 1);
      n_checks++; if (f_data_valid !== 1'b0) $display("FAIL fwft_idle_valid: got %b want 0", f_data_valid); else n_pass++;
      step(1, 1, 8'hA5, 0, 0);
      $display("fwft write A5: dout %h valid %b", f_data_out, f_data_valid);
      n_checks++; if (f_data_out !== 8'hA5) $display("FAIL fwft_dout: got %h want a5", f_data_out); else n_pass++;
      n_checks++; if (f_data_valid !== 1'b1) $display("FAIL fwft_valid: got %b want 1", f_data_valid); else n_pass++;
      n_checks++; if (data_valid !== 1'b0) $display("FAIL std_no_read_valid: got %b want 0", data_valid); else n_pass++;
      step(1, 0, 8'h00, 1, 0);
      $display("fwft pop: valid %b", f_data_valid);
      n_checks++; if (f_data_valid !== 1'b0) $display("FAIL fwft_pop_valid: got %b want 0", f_data_valid); else n_pass++;
      n_checks++; if (data_out !== exp_data) $display("FAIL fwft_std_data: got %h want %h", data_out, exp_data); else n_pass++;
   endtask

   task automatic test_mid_reset_flush();
      for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h40 + i), 0, 0);
      step(1, 0, 8'h00, 1, 0);
      n_checks++; if (level !== 4'd5 || data_valid !== 1'b1) $display("FAIL pre_rst: got level %0d valid %b want 5/1", level, data_valid); else n_pass++;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      $display("mid reset: level %0d dout %h valid %b", level, data_out, data_valid);
      n_checks++; if (level !== 4'd0) $display("FAIL mrst_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (data_out !== 8'h00) $display("FAIL mrst_dout: got %h want 00", data_out); else n_pass++;
      n_checks++; if (data_valid !== 1'b0) $display("FAIL mrst_valid: got %b want 0", data_valid); else n_pass++;
      #1 reset = 1'b1;
      sb.delete(); mdl_cnt = 0; mdl_ovf = 1'b0; mdl_udf = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h60 + i), 0, 0);
      step(1, 1, 8'h77, 0, 1);
      $display("flush+write: level %0d ovf %b", level, overflow);
      n_checks++; if (level !== 4'd0 || fifo_empty !== 1'b1) $display("FAIL flush_level: got %0d/%b want 0/1", level, fifo_empty); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL flush_ovf: got %b want 0", overflow); else n_pass++;
      step(1, 0, 8'h00, 1, 0);
      n_checks++; if (data_valid !== 1'b0 || level !== 4'd0) $display("FAIL flush_discard: got valid %b level %0d want 0/0", data_valid, level); else n_pass++;
      n_checks++; if (underflow !== mdl_udf) $display("FAIL flush_udf: got %b want %b", underflow, mdl_udf); else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_simultaneous();
      test_wrap();
      test_fwft();
      test_mid_reset_flush();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
